// File: rtl/centimos_euros_seq.sv
// Sequential cents-to-euros converter: bit-serial restoring division by DIVISOR behind
// valid/ready handshakes, with saturation of the euros quotient. Optional BCD output: CENTIMOS_EUROS_BCD_EN.
module centimos_euros_seq #(
  parameter int CENT_W  = 14,
  parameter int EUR_W   = 8,
  parameter int DIVISOR = 100,
  parameter int REM_W   = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CENT_W-1:0] centimos,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EUR_W-1:0]  eurosinteiros,
  output logic [REM_W-1:0]  eurosfracao,
  output logic              ovf
`ifdef CENTIMOS_EUROS_BCD_EN
  ,
  output logic [7:0]        fracao_bcd
`endif
);

  localparam int CNT_W = (CENT_W > 1) ? $clog2(CENT_W) : 1;
  localparam int RW1   = REM_W + 1;
  localparam int RW2   = REM_W + 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CENT_W - 1);
  localparam logic [RW2-1:0]   DIV_C    = RW2'(DIVISOR);
  localparam logic [31:0]      EUR_MAX  = 32'((64'd1 << EUR_W) - 64'd1);

  if (CENT_W < 2 || CENT_W > 31) begin : g_bad_cent_w
    $error("centimos_euros_seq: CENT_W must be in 2..31");
  end
  if (EUR_W < 1 || EUR_W > 31) begin : g_bad_eur_w
    $error("centimos_euros_seq: EUR_W must be in 1..31");
  end
  if (DIVISOR < 2 || DIVISOR >= (1 << REM_W)) begin : g_bad_divisor
    $error("centimos_euros_seq: need 2 <= DIVISOR < 2**REM_W");
  end
`ifdef CENTIMOS_EUROS_BCD_EN
  if (DIVISOR > 100) begin : g_bad_bcd
    $error("centimos_euros_seq: BCD output requires DIVISOR <= 100");
  end
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_HOLD
  } state_e;

  state_e              state_q, state_d;
  logic [CENT_W-1:0]   dvd_q, dvd_d;
  logic [RW1-1:0]      rem_q, rem_d;
  logic [CENT_W-1:0]   quo_q, quo_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [EUR_W-1:0]    eur_q, eur_d;
  logic [REM_W-1:0]    frac_q, frac_d;
  logic                ovf_q, ovf_d;
`ifdef CENTIMOS_EUROS_BCD_EN
  logic [7:0]          bcd_q, bcd_d;
  logic [7:0]          frac8;
`endif

  // One restoring-division step: bring in the next dividend bit, subtract if it fits.
  logic [RW2-1:0]    rem_shift;
  logic [RW2-1:0]    rem_next;
  logic              rem_ge;
  logic [CENT_W-1:0] quo_next;
  logic [31:0]       quo_ext;
  logic              sat;

  always_comb begin
    rem_shift = {rem_q, dvd_q[CENT_W-1]};
    rem_ge    = (rem_shift >= DIV_C);
    rem_next  = rem_ge ? (rem_shift - DIV_C) : rem_shift;
    quo_next  = (quo_q << 1) | CENT_W'(rem_ge);
    quo_ext   = 32'(quo_next);
    sat       = (quo_ext > EUR_MAX);
  end

`ifdef CENTIMOS_EUROS_BCD_EN
  always_comb begin
    frac8 = 8'(rem_next);
  end
`endif

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case can infer a latch.
    state_d = state_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    eur_d   = eur_q;
    frac_d  = frac_q;
    ovf_d   = ovf_q;
`ifdef CENTIMOS_EUROS_BCD_EN
    bcd_d   = bcd_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          dvd_d   = centimos;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = CNT_LAST;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        dvd_d = dvd_q << 1;
        rem_d = RW1'(rem_next);
        quo_d = quo_next;
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          frac_d  = REM_W'(rem_next);
          ovf_d   = sat;
          eur_d   = sat ? '1 : EUR_W'(quo_ext);
`ifdef CENTIMOS_EUROS_BCD_EN
          bcd_d   = {4'(frac8 / 8'd10), 4'(frac8 % 8'd10)};
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        // Results stay in their registers after consumption; only the handshake changes.
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      eur_q   <= '0;
      frac_q  <= '0;
      ovf_q   <= 1'b0;
`ifdef CENTIMOS_EUROS_BCD_EN
      bcd_q   <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      eur_q   <= eur_d;
      frac_q  <= frac_d;
      ovf_q   <= ovf_d;
`ifdef CENTIMOS_EUROS_BCD_EN
      bcd_q   <= bcd_d;
`endif
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign out_valid     = (state_q == S_HOLD);
  assign eurosinteiros = eur_q;
  assign eurosfracao   = frac_q;
  assign ovf           = ovf_q;
`ifdef CENTIMOS_EUROS_BCD_EN
  assign fracao_bcd    = bcd_q;
`endif

endmodule

// File: doc/centimos_euros_seq.md
Name: centimos_euros_seq

Overview:
Sequential, parametrised successor to the combinational cents-to-euros converter in the Balanca datapath. It accepts a cents value over a valid/ready handshake and runs a bit-serial restoring division by DIVISOR. It then presents whole euros and the fractional cents to the display/pricing logic.
Adds backpressure, fixed-latency iterative division, configurable widths and euro-overflow saturation.

Parameters:
CENT_W, 14, width of the input cents value (max 16383 cents by default).
EUR_W, 8, width of the whole-euros output; quotient saturates to this width.
DIVISOR, 100, constant divisor (cents per euro); must satisfy 2 <= DIVISOR < 2^REM_W.
REM_W, 7, width of the fractional-cents output; must satisfy 2^REM_W >= DIVISOR.

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  input cents value present
in_ready  out  1  block can accept a value
centimos  in  CENT_W  cents value, sampled on accepting edge
out_valid  out  1  result valid, held until consumed
out_ready  in  1  downstream consumes result
eurosinteiros  out  EUR_W  whole euros (saturated quotient)
eurosfracao  out  REM_W  remainder cents, 0..DIVISOR-1
ovf  out  1  quotient exceeded 2^EUR_W-1 (qualified by out_valid)

Behaviour:
- Reset: rst_n low at a rising edge sets state IDLE. On the next cycle in_ready=1, out_valid=0, eurosinteiros=0, eurosfracao=0, ovf=0 and all internal registers are cleared. Reset applies in any state; an in-flight division is discarded.
- State IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch centimos into the dividend shift register, clear the partial remainder, load bit counter = CENT_W-1 and go to DIV.
- State DIV:
  - in_ready=0; in_valid is ignored.
  - Each cycle: rem = {rem, dividend MSB}. If rem >= DIVISOR, subtract DIVISOR and shift quotient bit 1; otherwise shift 0.
  - Partial remainder is REM_W+1 bits wide; the quotient is CENT_W bits internally.
  - After the step with counter = 0, register the outputs and go to HOLD.
- Fixed latency: out_valid rises exactly CENT_W rising edges after the accepting edge, independent of data value.
- Output registration on DIV exit:
  - eurosfracao = final remainder.
  - If quotient > 2^EUR_W-1: eurosinteiros = all ones and ovf=1.
  - Otherwise: eurosinteiros = quotient[EUR_W-1:0] and ovf=0.
- State HOLD:
  - out_valid=1 and in_ready=0; outputs are stable while out_ready=0.
  - On out_ready=1, go to IDLE next cycle: out_valid drops, in_ready rises, and the output values are retained.
- Simultaneous events: because in_ready=0 in HOLD, consume and accept never overlap. Minimum issue interval is CENT_W+2 cycles with out_ready tied high.
- centimos may change freely outside the accepting edge.
- Input 0 gives 0/0; input exactly a multiple of DIVISOR gives remainder 0.

Optional Feature:
Macro CENTIMOS_EUROS_BCD_EN.
- Defined:
  - Adds output fracao_bcd [7:0]: {tens, units} BCD of eurosfracao, registered in the same cycle as eurosinteiros.
  - Reset value 8'h00.
  - Requires DIVISOR <= 100; elaboration error otherwise.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- centimos=470, out_ready=1 -> after 14 edges: eurosinteiros=4, eurosfracao=70, ovf=0; BCD build fracao_bcd=8'h70.
- Sweep 0, 99, 100, 16383 -> 0/0, 0/99, 1/0, 163/83; each out_valid exactly 14 edges after acceptance.
- EUR_W=6, centimos=16383 -> eurosinteiros=63, eurosfracao=83, ovf=1; then 6300 -> 63/0 with ovf=0.
- Backpressure: result 470 held with out_ready=0 for 5 cycles while in_valid=1, centimos=999 -> outputs stay 4/70 and in_ready stays 0. Then out_ready=1 -> IDLE, and 999 is accepted next and yields 9/99.
- Reset mid-DIV: rst_n low 1 cycle at division step 7 of centimos=5000 -> next cycle all outputs 0, in_ready=1, and no out_valid is produced for the aborted operation.
- Random 1000 values with random out_ready -> every result equals centimos/100 and centimos%100 (saturated per EUR_W); no accept occurs while in_ready=0.
